// File: rtl/bit_normalizer.sv
// Multi-cycle left normalizer: shifts one bit per cycle until the MSB is set,
// reporting the normalized word, its shift count and an all-zero flag.
module bit_normalizer #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_shift,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [SW-1:0] CMAX = SW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_cnt;
  logic             r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_data == '0) begin
            r_zero  <= 1'b1;
            r_state <= DONE;
          end else if (r_data[WIDTH-1]) begin
            r_state <= DONE;
          end else begin
            r_data <= r_data << 1;
            // Unreachable for nonzero input, but never wrap.
            if (r_cnt != CMAX) r_cnt <= r_cnt + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_data;
  assign out_shift = r_cnt;
  assign out_zero  = r_zero;

endmodule
